// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle control unit: FSM states, instruction fields, opcode,
// command, condition and write-data-mux encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // Latched instruction word; field order matches {opcodes, operation, condicion}.
  typedef struct packed {
    logic       regoffs;
    logic [3:0] cmd;
    logic       sl;
    logic [1:0] op;
    logic [3:0] cond;
  } ir_t;

  localparam logic [1:0] OP_DATA   = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] DI_ALU = 2'b00;
  localparam logic [1:0] DI_OPB = 2'b01;
  localparam logic [1:0] DI_MEM = 2'b10;
  localparam logic [1:0] DI_PC4 = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_cond_eval.sv
// ARM condition-code evaluator: pass = cond holds for the given {N,Z,C,V}.
// Purely combinational, no handshake.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with latched IR and NZCV flags register.
// Latency: data/branch 4, store 3+w, load 4+w, cond-fail 2 cycles (w = cycles to mem_ack).
// Backpressure: mem_req held until mem_ack; MEM_TIMEOUT_EN adds a sticky FAULT on a stalled MEM.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int         OPALU_W     = 4,
  parameter logic [3:0] FLAGS_RST   = 4'b0000,
  parameter int         TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [5:0]         opcodes,
  input  logic [1:0]         operation,
  input  logic [3:0]         condicion,
  input  logic [3:0]         alu_flags,
  input  logic               mem_ack,
  output logic               ir_load,
  output logic               pc_en,
  output logic               selPC,
  output logic               regWr,
  output logic               selAddB,
  output logic               selAddWr,
  output logic [OPALU_W-1:0] opALU,
  output logic               cin,
  output logic [1:0]         selDiWr,
  output logic               selOperaB,
  output logic               logicalOperation,
  output logic               mem_req,
  output logic               mem_we,
  output logic [3:0]         flags,
  output logic               busy,
  output logic               fault
);

  state_t     state, state_nx;
  ir_t        ir;
  logic [3:0] flags_q;
  logic       cond_pass, is_cmp, flags_ld;

  logic       ir_load_c, pc_en_c, selpc_c, regwr_c, seladdb_c, seladdwr_c;
  logic       cin_c, opb_c, logic_c, mem_req_c, mem_we_c;
  logic [3:0] opalu_c;
  logic [1:0] di_c;

  cond_eval u_cond_eval (
    .cond (ir.cond),
    .nzcv (flags_q),
    .pass (cond_pass)
  );

  assign is_cmp = (ir.cmd == CMD_CMP);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Held at zero outside MEM, so every MEM visit starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state != MEM) tmo_cnt <= '0;
    else if (!mem_ack)       tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      ir      <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      state <= state_nx;
      if (ir_load_c) ir <= ir_t'({opcodes, operation, condicion});
      if (flags_ld)  flags_q <= alu_flags;
    end
  end

  always_comb begin
    state_nx   = state;
    ir_load_c  = 1'b0;
    pc_en_c    = 1'b0;
    selpc_c    = 1'b0;
    regwr_c    = 1'b0;
    seladdb_c  = 1'b0;
    seladdwr_c = 1'b0;
    opalu_c    = 4'b0000;
    cin_c      = 1'b0;
    di_c       = DI_ALU;
    opb_c      = 1'b0;
    logic_c    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    flags_ld   = 1'b0;
    case (state)
      FETCH: begin
        if (instr_valid) begin
          ir_load_c = 1'b1;
          state_nx  = DECODE;
        end
      end
      DECODE: begin
        if (!cond_pass || ir.op == OP_UNDEF) begin
          pc_en_c  = 1'b1;
          state_nx = FETCH;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        case (ir.op)
          OP_DATA: begin
            opalu_c  = is_cmp ? CMD_SUB : ir.cmd;
            cin_c    = (ir.cmd == CMD_SUB) || is_cmp;
            logic_c  = (ir.cmd == CMD_AND);
            opb_c    = ir.regoffs;
            di_c     = (ir.cmd == CMD_MOV) ? DI_OPB : DI_ALU;
            flags_ld = ir.sl || is_cmp;
            state_nx = WB;
          end
          OP_MEM: begin
            seladdb_c = 1'b1;
            opalu_c   = ir.cmd[2] ? CMD_ADD : CMD_SUB;
            opb_c     = ~ir.regoffs;
            state_nx  = MEM;
          end
          default: begin
            opalu_c  = CMD_AND;
            state_nx = WB;
          end
        endcase
      end
      MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = ~ir.sl;
        if (mem_ack) begin
          if (ir.sl) begin
            state_nx = WB;
          end else begin
            pc_en_c  = 1'b1;
            state_nx = FETCH;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nx = FAULT;
        end
`endif
      end
      WB: begin
        pc_en_c  = 1'b1;
        state_nx = FETCH;
        case (ir.op)
          OP_DATA: regwr_c = ~is_cmp;
          OP_MEM: begin
            regwr_c = 1'b1;
            di_c    = DI_MEM;
          end
          default: begin
            selpc_c = 1'b1;
            if (ir.cmd[3]) begin
              regwr_c    = 1'b1;
              seladdwr_c = 1'b1;
              di_c       = DI_PC4;
            end
          end
        endcase
      end
`ifdef MEM_TIMEOUT_EN
      FAULT: state_nx = FAULT;
`endif
      default: state_nx = FETCH;
    endcase
  end

  // All outputs are forced low while rst is high, even before the reset edge lands.
  assign ir_load          = ir_load_c & ~rst;
  assign pc_en            = pc_en_c & ~rst;
  assign selPC            = selpc_c & ~rst;
  assign regWr            = regwr_c & ~rst;
  assign selAddB          = seladdb_c & ~rst;
  assign selAddWr         = seladdwr_c & ~rst;
  assign opALU            = rst ? '0 : OPALU_W'(opalu_c);
  assign cin              = cin_c & ~rst;
  assign selDiWr          = rst ? 2'b00 : di_c;
  assign selOperaB        = opb_c & ~rst;
  assign logicalOperation = logic_c & ~rst;
  assign mem_req          = mem_req_c & ~rst;
  assign mem_we           = mem_we_c & ~rst;
  assign flags            = rst ? 4'b0000 : flags_q;
  assign busy             = (state != FETCH) & ~rst;
`ifdef MEM_TIMEOUT_EN
  assign fault            = (state == FAULT) & ~rst;
`else
  assign fault            = 1'b0;
`endif

endmodule
